// File: rtl/alarm_pkg.sv
// Shared types for the alarm event reporter.
// Alarm state encodings, TX FSM states, record field widths.
package alarm_pkg;

  localparam int SEQ_W = 4;
  localparam int ST_W  = 2;
  localparam int REC_W = SEQ_W + 2 * ST_W;

  typedef enum logic [ST_W-1:0] {
    OFF       = 2'b00,
    ARMED     = 2'b01,
    TRIGGERED = 2'b10,
    ALARM_ON  = 2'b11
  } alarm_st_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_st_t;

  function automatic logic [REC_W-1:0] mk_rec(
    input logic [SEQ_W-1:0] seq,
    input logic [ST_W-1:0]  from,
    input logic [ST_W-1:0]  to
  );
    return {seq, from, to};
  endfunction

endpackage

// File: rtl/alarm_evt_fifo.sv
// Event record FIFO, pop takes effect before push when full.
// Ports: clk, rst, push/din, pop/dout, full, empty.
module alarm_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          rd_en;
  logic          wr_en;

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign dout  = mem[rp];

  // No bypass on empty; a full FIFO frees
  // the head slot first, so the push fits.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wp] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr_en) begin
        wp <= wp + 1'b1;
      end
      if (rd_en) begin
        rp <= rp + 1'b1;
      end
      unique case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/alarm_event_tx.sv
// Alarm FSM event reporter: records state changes, sends UART frames.
// Ports: clk, rst, state_in[1:0] -> tx, busy, pending, overflow.
// Option: ALARM_TX_PARITY_EN adds an even parity bit after the data.
module alarm_event_tx
  import alarm_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ST_W-1:0] state_in,
  output logic            tx,
  output logic            busy,
  output logic            pending,
  output logic            overflow
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] BIT_LAST =
    CNT_W'(CLKS_PER_BIT - 1);

  logic [ST_W-1:0]  prev_state;
  logic [SEQ_W-1:0] seq;
  logic             evt;
  logic             accept;
  logic [REC_W-1:0] rec;

  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [REC_W-1:0] fifo_dout;

  tx_st_t           tx_st;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             bit_end;
`ifdef ALARM_TX_PARITY_EN
  logic             par;
`endif

  assign evt = (state_in != prev_state);
  assign rec = mk_rec(seq, prev_state, state_in);

  // Head is popped only from IDLE.
  assign fifo_pop = (tx_st == TX_IDLE) && !fifo_empty;

  // Mirrors the FIFO's own write-enable rule.
  assign accept = evt && (!fifo_full || fifo_pop);

  assign pending = !fifo_empty;
  assign bit_end = (clk_cnt == BIT_LAST);

  alarm_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (evt),
    .din   (rec),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_state <= OFF;
      seq        <= '0;
      overflow   <= 1'b0;
    end else begin
      prev_state <= state_in;
      if (accept) begin
        seq <= seq + 1'b1;
      end
      if (evt && !accept) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st   <= TX_IDLE;
      tx      <= 1'b1;
      busy    <= 1'b0;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
`ifdef ALARM_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      unique case (tx_st)
        TX_IDLE: begin
          if (!fifo_empty) begin
            shreg   <= fifo_dout;
`ifdef ALARM_TX_PARITY_EN
            par     <= ^fifo_dout;
`endif
            tx_st   <= TX_START;
            tx      <= 1'b0;
            busy    <= 1'b1;
            clk_cnt <= '0;
            bit_cnt <= '0;
          end
        end
        TX_START: begin
          if (bit_end) begin
            tx_st   <= TX_DATA;
            tx      <= shreg[0];
            clk_cnt <= '0;
            bit_cnt <= '0;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
`ifdef ALARM_TX_PARITY_EN
              tx_st   <= TX_PARITY;
              tx      <= par;
`else
              tx_st   <= TX_STOP;
              tx      <= 1'b1;
`endif
            end else begin
              // Next bit is shreg[1] before shift.
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= {1'b0, shreg[7:1]};
              tx      <= shreg[1];
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`ifdef ALARM_TX_PARITY_EN
        TX_PARITY: begin
          if (bit_end) begin
            tx_st   <= TX_STOP;
            tx      <= 1'b1;
            clk_cnt <= '0;
            bit_cnt <= '0;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`endif
        TX_STOP: begin
          if (bit_end) begin
            // One IDLE cycle always follows STOP.
            tx_st   <= TX_IDLE;
            tx      <= 1'b1;
            busy    <= 1'b0;
            clk_cnt <= '0;
            bit_cnt <= '0;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: begin
          tx_st   <= TX_IDLE;
          tx      <= 1'b1;
          busy    <= 1'b0;
          clk_cnt <= '0;
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_event_tx.sv
// Directed bench for alarm_event_tx.
// Frame monitor decodes tx; initial block drives steps.
module tb_alarm_event_tx;

  localparam int CPB = 8;
`ifdef ALARM_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL  = NB * CPB;
  localparam int TMO = 20 * FL;

  logic       clk;
  logic       rst;
  logic [1:0] state_in;
  logic       tx;
  logic       busy;
  logic       pending;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] rx_d [$];
  int         rx_t [$];
  logic       rx_p [$];
  logic       rx_ok [$];

  alarm_event_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .state_in (state_in),
    .tx       (tx),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Frame decoder: samples each bit mid-way;
  // any frame overlapping rst is discarded.
  initial begin
    logic [10:0] b;
    int          t0;
    logic        hit;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        t0  = cyc;
        hit = 1'b0;
        b   = '0;
        for (int i = 0; i < NB; i++) begin
          repeat ((i == 0) ? CPB / 2 : CPB)
            @(negedge clk);
          if (rst) hit = 1'b1;
          b[i] = tx;
        end
        if (!hit) begin
          rx_d.push_back(b[8:1]);
          rx_t.push_back(t0);
          rx_p.push_back(b[9]);
          rx_ok.push_back(!b[0] && b[NB-1]);
        end
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic get_frame(output logic [7:0] d,
                           output int t,
                           output logic p,
                           output logic ok);
    int n = 0;
    while (rx_d.size() == 0 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (rx_d.size() == 0) begin
      d = 8'hxx; t = 0; p = 1'bx; ok = 1'b0;
    end else begin
      d  = rx_d.pop_front();
      t  = rx_t.pop_front();
      p  = rx_p.pop_front();
      ok = rx_ok.pop_front();
    end
  endtask

  task automatic do_reset(input int n);
    rst      = 1'b1;
    state_in = 2'b00;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    rx_d.delete();
    rx_t.delete();
    rx_p.delete();
    rx_ok.delete();
  endtask

  task automatic clr_q();
    rx_d.delete();
    rx_t.delete();
    rx_p.delete();
    rx_ok.delete();
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] acc;
    logic       p;
    logic       ok;
    int         t;
    int         tp;
    logic       bad;
    logic [7:0] exp3 [5];
    logic [7:0] e;

    rst      = 1'b1;
    state_in = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_pending", pending, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single event, bit-exact timing.
    state_in = 2'b01;
    @(negedge clk);
    chk("t1_pend", pending, 1);
    chk("t1_tx_pre", tx, 1);
    @(negedge clk);
    chk("t1_start", tx, 0);
    chk("t1_busy", busy, 1);
    chk("t1_pend0", pending, 0);
    repeat (CPB - 1) @(negedge clk);
    chk("t1_start_end", tx, 0);
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      acc[i] = tx;
      repeat (CPB - 1) @(negedge clk);
    end
    chk("t1_data", acc, 8'h01);
`ifdef ALARM_TX_PARITY_EN
    @(negedge clk);
    chk("t1_par", tx, 1);
    repeat (CPB - 1) @(negedge clk);
`endif
    @(negedge clk);
    chk("t1_stop", tx, 1);
    chk("t1_stop_busy", busy, 1);
    repeat (CPB) @(negedge clk);
    chk("t1_idle_busy", busy, 0);
    bad = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || pending !== 1'b0)
        bad = 1'b1;
    end
    chk("t1_quiet", bad, 0);
    clr_q();

    // 2: back-to-back transitions.
    do_reset(2);
    @(negedge clk);
    state_in = 2'b01;
    @(negedge clk);
    state_in = 2'b10;
    @(negedge clk);
    state_in = 2'b11;
    get_frame(d, tp, p, ok);
    chk("t2_f0", d, 8'h01);
    get_frame(d, t, p, ok);
    chk("t2_f1", d, 8'h16);
    chk("t2_gap1", t - tp, FL + 1);
    tp = t;
`ifdef ALARM_TX_PARITY_EN
    chk("t5_par16", p, 1);
`endif
    get_frame(d, t, p, ok);
    chk("t2_f2", d, 8'h2B);
    chk("t2_gap2", t - tp, FL + 1);
    chk("t2_frm", ok, 1);
    chk("t2_ovf", overflow, 0);

    // 3: overflow with depth 4.
    do_reset(2);
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      state_in = (i % 2 == 0) ? 2'b01 : 2'b00;
      @(negedge clk);
    end
    chk("t3_ovf", overflow, 1);
    chk("t3_pend", pending, 1);
    exp3[0] = 8'h01;
    exp3[1] = 8'h14;
    exp3[2] = 8'h21;
    exp3[3] = 8'h34;
    exp3[4] = 8'h41;
    for (int i = 0; i < 5; i++) begin
      get_frame(d, t, p, ok);
      chk($sformatf("t3_f%0d", i), d, exp3[i]);
    end
    repeat (3 * FL) @(negedge clk);
    chk("t3_nomore", rx_d.size(), 0);
    chk("t3_ovf_hold", overflow, 1);
    chk("t3_empty", pending, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("t3_ovf_clr", overflow, 0);

    // 4: reset in DATA bit 3.
    do_reset(2);
    @(negedge clk);
    state_in = 2'b10;
    @(negedge clk);
    state_in = 2'b11;
    @(negedge clk);
    // Start began on the edge before this point.
    repeat (CPB + 3 * CPB + 2) @(negedge clk);
    chk("t4_busy_pre", busy, 1);
    rst      = 1'b1;
    state_in = 2'b00;
    @(negedge clk);
    chk("t4_tx", tx, 1);
    chk("t4_busy", busy, 0);
    chk("t4_pend", pending, 0);
    repeat (CPB + 2) @(negedge clk);
    rst = 1'b0;
    clr_q();
    repeat (3 * FL) @(negedge clk);
    chk("t4_noresume", rx_d.size(), 0);
    chk("t4_tx_idle", tx, 1);
    state_in = 2'b10;
    get_frame(d, t, p, ok);
    chk("t4_new", d, 8'h02);

    // 5: seq wraps after 16 accepted events.
    do_reset(2);
    @(negedge clk);
    for (int k = 0; k < 17; k++) begin
      state_in = (k % 2 == 0) ? 2'b01 : 2'b00;
      get_frame(d, t, p, ok);
      e = {4'(k % 16),
           (k % 2 == 0) ? 4'b0001 : 4'b0100};
      if (k >= 14)
        chk($sformatf("t5_seq%0d", k), d, e);
    end

    // 6: long idle.
    do_reset(2);
    bad = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 ||
          pending !== 1'b0)
        bad = 1'b1;
    end
    chk("t6_idle", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
